// File: rtl/object_scheduler_if.sv
// Signal bundle between the game FSM side (master) and the falling-object scheduler (slave).
// Slot order for the packed bits is [0] bug, [1] green, [2] orange, [3] yellow.
interface object_scheduler_if;
  logic       run;
  logic       tick;
  logic [2:0] farmer_x;
  logic [2:0] bug_x, green_x, orange_x, yellow_x;
  logic [9:0] bug_y, green_y, orange_y, yellow_y;
  logic [3:0] obj_active;
  logic [3:0] catch_pulse;
  logic [5:0] score_pos;
  logic [5:0] score_neg;

  modport master (
    output run, tick, farmer_x,
    input  bug_x, green_x, orange_x, yellow_x,
    input  bug_y, green_y, orange_y, yellow_y,
    input  obj_active, catch_pulse, score_pos, score_neg
  );

  modport slave (
    input  run, tick, farmer_x,
    output bug_x, green_x, orange_x, yellow_x,
    output bug_y, green_y, orange_y, yellow_y,
    output obj_active, catch_pulse, score_pos, score_neg
  );
endinterface

// File: rtl/object_scheduler.sv
// Spawns, advances and catches the four falling sprites and keeps the fruit/bug scores.
// Slot 0 is the bug; slots 1..3 are green, orange and yellow fruit.
module object_scheduler #(
  parameter int         FALL_STEP = 4,
  parameter int         SPAWN_GAP = 20,
  parameter int         CATCH_Y   = 320,
  parameter int         OFF_Y     = 480,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  object_scheduler_if.slave bus
);
  localparam int               CNT_W     = $clog2(SPAWN_GAP + 1);
  localparam logic [CNT_W-1:0] GAP       = CNT_W'(SPAWN_GAP);
  localparam logic [9:0]       OFF_Y10   = 10'(OFF_Y);
  localparam logic [10:0]      OFF_Y11   = 11'(OFF_Y);
  localparam logic [10:0]      CATCH_Y11 = 11'(CATCH_Y);
  localparam logic [10:0]      STEP11    = 11'(FALL_STEP);

  logic [3:0][2:0]  x_reg, x_next;
  logic [3:0][9:0]  y_reg, y_next;
  logic [3:0]       active_reg, active_next;
  logic [3:0]       catch_reg, catch_next;
  logic [5:0]       score_pos_reg, score_pos_next;
  logic [5:0]       score_neg_reg, score_neg_next;
  logic [7:0]       lfsr_reg, lfsr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [1:0]       ptr_reg, ptr_next;
  logic             run_reg;

  logic [3:0][10:0] y_new;
  logic [3:0]       caught, missed;
  logic             spawn_found;
  logic [1:0]       spawn_slot;
  logic [7:0]       lfsr_step;
  logic [7:0]       pos_sum, neg_sum;

  function automatic logic [5:0] sat6(input logic [7:0] v);
    return (v > 8'd63) ? 6'd63 : v[5:0];
  endfunction

  // Fall arithmetic is 11 bits wide so the OFF_Y comparison never wraps.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign y_new[gi]  = {1'b0, y_reg[gi]} + STEP11;
    assign caught[gi] = active_reg[gi] && ({1'b0, y_reg[gi]} < CATCH_Y11) &&
                        (y_new[gi] >= CATCH_Y11) && (x_reg[gi] == bus.farmer_x);
    assign missed[gi] = active_reg[gi] && !caught[gi] && (y_new[gi] >= OFF_Y11);
  end

  // Round-robin search from the pointer over the pre-tick idle slots.
  always_comb begin
    spawn_found = 1'b0;
    spawn_slot  = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (!active_reg[ptr_reg + 2'(k)]) begin
        spawn_found = 1'b1;
        spawn_slot  = ptr_reg + 2'(k);
      end
    end
  end

  assign lfsr_step = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);
  assign cnt_inc   = cnt_reg + 1'b1;
  assign pos_sum   = {2'b00, score_pos_reg} + (caught[1] ? 8'd1 : 8'd0) +
                     (caught[2] ? 8'd2 : 8'd0) + (caught[3] ? 8'd3 : 8'd0);
  assign neg_sum   = {2'b00, score_neg_reg} + (caught[0] ? 8'd3 : 8'd0);

  always_comb begin
    x_next         = x_reg;
    y_next         = y_reg;
    active_next    = active_reg;
    catch_next     = '0;
    score_pos_next = score_pos_reg;
    score_neg_next = score_neg_reg;
    lfsr_next      = lfsr_reg;
    cnt_next       = cnt_reg;
    ptr_next       = ptr_reg;
    if (!bus.run) begin
      active_next = '0;
      y_next      = {4{OFF_Y10}};
      cnt_next    = '0;
    end else if (!run_reg) begin
      score_pos_next = '0;
      score_neg_next = '0;
      cnt_next       = '0;
      lfsr_next      = LFSR_SEED;
      ptr_next       = 2'd1;
    end else if (bus.tick) begin
      for (int s = 0; s < 4; s++) begin
        if (caught[s] || missed[s]) begin
          active_next[s] = 1'b0;
          y_next[s]      = OFF_Y10;
        end else if (active_reg[s]) begin
          y_next[s] = y_new[s][9:0];
        end
      end
      catch_next     = caught;
      score_pos_next = sat6(pos_sum);
      score_neg_next = sat6(neg_sum);
      if (cnt_inc == GAP) begin
        cnt_next = '0;
        if (spawn_found) begin
          x_next[spawn_slot]      = lfsr_reg[2:0];
          y_next[spawn_slot]      = '0;
          active_next[spawn_slot] = 1'b1;
          ptr_next                = spawn_slot + 2'd1;
          lfsr_next               = lfsr_step;
        end
      end else begin
        cnt_next = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg         <= '0;
      y_reg         <= {4{OFF_Y10}};
      active_reg    <= '0;
      catch_reg     <= '0;
      score_pos_reg <= '0;
      score_neg_reg <= '0;
      lfsr_reg      <= LFSR_SEED;
      cnt_reg       <= '0;
      ptr_reg       <= 2'd1;
      run_reg       <= 1'b0;
    end else begin
      x_reg         <= x_next;
      y_reg         <= y_next;
      active_reg    <= active_next;
      catch_reg     <= catch_next;
      score_pos_reg <= score_pos_next;
      score_neg_reg <= score_neg_next;
      lfsr_reg      <= lfsr_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      run_reg       <= bus.run;
    end
  end

  assign bus.bug_x       = x_reg[0];
  assign bus.green_x     = x_reg[1];
  assign bus.orange_x    = x_reg[2];
  assign bus.yellow_x    = x_reg[3];
  assign bus.bug_y       = y_reg[0];
  assign bus.green_y     = y_reg[1];
  assign bus.orange_y    = y_reg[2];
  assign bus.yellow_y    = y_reg[3];
  assign bus.obj_active  = active_reg;
  assign bus.catch_pulse = catch_reg;
  assign bus.score_pos   = score_pos_reg;
  assign bus.score_neg   = score_neg_reg;
endmodule
